sum_accumulator: RTL and testbench

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

---
 rtl/sum_accumulator_if.sv | 33 +++
 rtl/sum_accumulator.sv | 114 +++++++++++
 tb/tb_sum_accumulator.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/sum_accumulator_if.sv
// Sample-in / frame-result-out handshake bundle for sum_accumulator.
// The DUT side uses the slave modport; the producer/consumer side uses master.
interface sum_accumulator_if #(
  parameter int unsigned ACC_W = 8
);
  logic             in_valid;
  logic [4:0]       in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_sat;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_sat
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_sat
  );
endinterface

// File: rtl/sum_accumulator.sv
// Saturating frame accumulator: sums COUNT_N signed 5-bit samples into an
// ACC_W-bit result and holds it until the downstream consumer takes it.
module sum_accumulator #(
  parameter int unsigned COUNT_N = 4,
  parameter int unsigned ACC_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  clear,
  output logic                  busy,
  sum_accumulator_if.slave      bus
);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  localparam logic [7:0] CntLast = 8'(COUNT_N);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             sat_q, sat_d;

  logic [ACC_W:0]   sum_wide;
  logic             pos_ovf, neg_ovf;
  logic [ACC_W-1:0] acc_clamped;
  logic [7:0]       cnt_inc;

  // Both operands fit in ACC_W signed bits, so the ACC_W+1 bit sum never wraps;
  // disagreement of its top two bits flags an out-of-range result.
  assign sum_wide = {acc_q[ACC_W-1], acc_q} + {{(ACC_W - 4){bus.in_data[4]}}, bus.in_data};
  assign pos_ovf  = ~sum_wide[ACC_W] & sum_wide[ACC_W-1];
  assign neg_ovf  = sum_wide[ACC_W] & ~sum_wide[ACC_W-1];
  assign cnt_inc  = cnt_q + 8'd1;

  always_comb begin
    acc_clamped = sum_wide[ACC_W-1:0];
    if (pos_ovf) begin
      acc_clamped = {1'b0, {(ACC_W - 1){1'b1}}};
    end else if (neg_ovf) begin
      acc_clamped = {1'b1, {(ACC_W - 1){1'b0}}};
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    if (clear) begin
      state_d = StIdle;
      acc_d   = '0;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StAccum;
            acc_d   = '0;
            cnt_d   = '0;
            sat_d   = 1'b0;
          end
        end
        StAccum: begin
          if (bus.in_valid) begin
            acc_d = acc_clamped;
            sat_d = sat_q | pos_ovf | neg_ovf;
            cnt_d = cnt_inc;
            if (cnt_inc == CntLast) begin
              state_d = StDone;
            end
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            state_d = StAccum;
            acc_d   = '0;
            cnt_d   = '0;
            sat_d   = 1'b0;
          end
        end
        default: begin
          state_d = StIdle;
          acc_d   = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  // Outputs decode straight from state so reset clears them without a clock.
  assign bus.in_ready  = (state_q == StAccum);
  assign bus.out_valid = (state_q == StDone);
  assign bus.out_data  = (state_q == StDone) ? acc_q : '0;
  assign bus.out_sat   = (state_q == StDone) ? sat_q : 1'b0;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: default-width instance plus an ACC_W=6
// instance for the saturation cases.
module tb_sum_accumulator;

  logic clk = 1'b0;
  logic rst_n;
  logic start_a, clear_a, busy_a;
  logic start_b, clear_b, busy_b;

  int checks   = 0;
  int failures = 0;

  sum_accumulator_if #(.ACC_W(8)) ifa ();
  sum_accumulator_if #(.ACC_W(6)) ifb ();

  sum_accumulator #(.COUNT_N(4), .ACC_W(8)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start_a),
    .clear (clear_a),
    .busy  (busy_a),
    .bus   (ifa)
  );

  sum_accumulator #(.COUNT_N(4), .ACC_W(6)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start_b),
    .clear (clear_b),
    .busy  (busy_b),
    .bus   (ifb)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic send_a(input logic [4:0] d);
    ifa.in_valid = 1'b1;
    ifa.in_data  = d;
    tick();
    ifa.in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [4:0] d);
    ifb.in_valid = 1'b1;
    ifb.in_data  = d;
    tick();
    ifb.in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start_a = 1'b0; clear_a = 1'b0; start_b = 1'b0; clear_b = 1'b0;
    ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.out_ready = 1'b0;
    ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.out_ready = 1'b0;

    #3;
    check("rst_in_ready", 16'(ifa.in_ready), 16'd0);
    check("rst_out_valid", 16'(ifa.out_valid), 16'd0);
    check("rst_out_data", 16'(ifa.out_data), 16'd0);
    check("rst_out_sat", 16'(ifa.out_sat), 16'd0);
    check("rst_busy", 16'(busy_a), 16'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("idle_wait_busy", 16'(busy_a), 16'd0);
    check("idle_wait_ready", 16'(ifa.in_ready), 16'd0);

    // Basic frame: 3 + 5 - 2 + 7 = 13; a start mid-frame must be ignored.
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("accum_ready", 16'(ifa.in_ready), 16'd1);
    check("accum_busy", 16'(busy_a), 16'd1);
    send_a(5'd3);
    start_a = 1'b1;
    send_a(5'd5);
    start_a = 1'b0;
    send_a(5'h1e);
    check("mid_out_valid", 16'(ifa.out_valid), 16'd0);
    check("mid_out_data", 16'(ifa.out_data), 16'd0);
    send_a(5'd7);
    check("f1_valid", 16'(ifa.out_valid), 16'd1);
    check("f1_data", 16'(ifa.out_data), 16'd13);
    check("f1_sat", 16'(ifa.out_sat), 16'd0);
    check("f1_ready", 16'(ifa.in_ready), 16'd0);

    // Hold result with out_ready low; an in_valid pulse must not be taken.
    for (int i = 0; i < 5; i++) begin
      check("hold_data", 16'(ifa.out_data), 16'd13);
      check("hold_ready", 16'(ifa.in_ready), 16'd0);
      ifa.in_valid = (i == 2);
      ifa.in_data  = 5'd1;
      tick();
    end
    ifa.in_valid = 1'b0;
    check("hold_end_valid", 16'(ifa.out_valid), 16'd1);
    check("hold_end_data", 16'(ifa.out_data), 16'd13);
    ifa.out_ready = 1'b1; tick(); ifa.out_ready = 1'b0;
    check("handoff_ready", 16'(ifa.in_ready), 16'd1);
    check("handoff_valid", 16'(ifa.out_valid), 16'd0);
    for (int i = 0; i < 4; i++) send_a(5'd2);
    check("f2_data", 16'(ifa.out_data), 16'd8);
    ifa.out_ready = 1'b1; tick(); ifa.out_ready = 1'b0;

    // Clear after two samples, then a fresh frame of +1s.
    send_a(5'd1);
    send_a(5'd1);
    clear_a = 1'b1; tick(); clear_a = 1'b0;
    check("clear_busy", 16'(busy_a), 16'd0);
    check("clear_ready", 16'(ifa.in_ready), 16'd0);
    repeat (2) tick();
    check("clear_no_valid", 16'(ifa.out_valid), 16'd0);
    start_a = 1'b1; tick(); start_a = 1'b0;
    for (int i = 0; i < 4; i++) send_a(5'd1);
    check("f3_valid", 16'(ifa.out_valid), 16'd1);
    check("f3_data", 16'(ifa.out_data), 16'd4);
    // clear beats the out handshake on the same edge
    ifa.out_ready = 1'b1; clear_a = 1'b1; tick(); ifa.out_ready = 1'b0; clear_a = 1'b0;
    check("clr_prio_busy", 16'(busy_a), 16'd0);
    check("clr_prio_valid", 16'(ifa.out_valid), 16'd0);

    // Asynchronous reset mid-frame.
    start_a = 1'b1; tick(); start_a = 1'b0;
    send_a(5'd1);
    send_a(5'd1);
    ifa.in_valid = 1'b1; ifa.in_data = 5'd1;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ready", 16'(ifa.in_ready), 16'd0);
    check("arst_busy", 16'(busy_a), 16'd0);
    check("arst_valid", 16'(ifa.out_valid), 16'd0);
    check("arst_data", 16'(ifa.out_data), 16'd0);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_valid", 16'(ifa.out_valid), 16'd0);
      check("post_rst_busy", 16'(busy_a), 16'd0);
    end
    ifa.in_valid = 1'b0;

    // Back-to-back frames with in_valid and out_ready held high.
    start_a = 1'b1; tick(); start_a = 1'b0;
    ifa.in_valid = 1'b1; ifa.in_data = 5'd1; ifa.out_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 4; k++) begin
        check("b2b_ready_hi", 16'(ifa.in_ready), 16'd1);
        tick();
      end
      check("b2b_valid", 16'(ifa.out_valid), 16'd1);
      check("b2b_data", 16'(ifa.out_data), 16'd4);
      check("b2b_ready_lo", 16'(ifa.in_ready), 16'd0);
      tick();
    end
    ifa.in_valid = 1'b0; ifa.out_ready = 1'b0;
    clear_a = 1'b1; tick(); clear_a = 1'b0;

    // ACC_W=6 saturation: limits are +31 and -32 (6'h20).
    start_b = 1'b1; tick(); start_b = 1'b0;
    send_b(5'd15);
    send_b(5'd15);
    send_b(5'd15);
    send_b(5'd1);
    check("satp_valid", 16'(ifb.out_valid), 16'd1);
    check("satp_data", 16'(ifb.out_data), 16'h001f);
    check("satp_sat", 16'(ifb.out_sat), 16'd1);
    ifb.out_ready = 1'b1; tick(); ifb.out_ready = 1'b0;
    check("satp_cleared", 16'(ifb.out_sat), 16'd0);
    for (int i = 0; i < 4; i++) send_b(5'h10);
    check("satn_data", 16'(ifb.out_data), 16'h0020);
    check("satn_sat", 16'(ifb.out_sat), 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
